mem_responder: RTL and testbench

Memory-side responder for the valid/ready memory channel protocol used between the memory controllers and global data or program memory. It serves NUM_CHANNELS independent request channels. Each channel has a fixed, configurable latency. All channels share one word-addressed storage array. It is the synthesizable replacement for the behavioural memory model in the test harness, and it is also used as the on-chip program and data store in FPGA builds.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder_channel.sv | 110 +++++++++++
 rtl/mem_responder.sv | 100 ++++++++++
 tb/tb_mem_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: channel FSM states,
// request opcode and the stall LFSR seed/step.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND, DRAIN} mem_resp_state_t;
    typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int unsigned CNT_BITS  = 5;

    // 16-bit Fibonacci LFSR step, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready memory channel bundle between memory controllers (master)
// and the memory responder (slave), one lane per channel.
interface mem_responder_if #(
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16
);

    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );

endinterface

// File: rtl/mem_responder_channel.sv
// One request channel: IDLE -> BUSY -> RESPOND -> DRAIN FSM with latency
// counter and latched request; commit_c marks the edge the array is accessed.
module mem_responder_channel
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic [1:0]           stall,
    output logic                 commit_c,
    output mem_op_t              op,
    output logic [ADDR_BITS-1:0] address,
    output logic [DATA_BITS-1:0] data,
    output logic                 read_ready,
    output logic                 write_ready
);

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_BUSY    = 2'(BUSY);
    localparam logic [1:0] S_RESPOND = 2'(RESPOND);
    localparam logic [1:0] S_DRAIN   = 2'(DRAIN);

    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(READ_LATENCY - 1);

    logic [1:0]           state, state_d;
    logic [CNT_BITS-1:0]  cnt, cnt_d;
    mem_op_t              op_d;
    logic [ADDR_BITS-1:0] address_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 read_ready_d, write_ready_d;
    logic                 take_write;

    assign take_write = (WRITE_ENABLE != 0) && write_valid;

    // Next-state and response logic; ready is a single-cycle pulse on RESPOND entry
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        op_d          = op;
        address_d     = address;
        data_d        = data;
        read_ready_d  = 1'b0;
        write_ready_d = 1'b0;
        commit_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (take_write) begin
                    state_d   = S_BUSY;
                    op_d      = OP_WRITE;
                    address_d = write_address;
                    data_d    = write_data;
                    cnt_d     = CNT_LOAD + CNT_BITS'(stall);
                end else if (read_valid) begin
                    state_d   = S_BUSY;
                    op_d      = OP_READ;
                    address_d = read_address;
                    cnt_d     = CNT_LOAD + CNT_BITS'(stall);
                end
            end
            S_BUSY: begin
                if (cnt == '0) begin
                    state_d       = S_RESPOND;
                    commit_c      = 1'b1;
                    read_ready_d  = (op == OP_READ);
                    write_ready_d = (op == OP_WRITE);
                end else begin
                    cnt_d = cnt - CNT_BITS'(1);
                end
            end
            S_RESPOND: state_d = S_DRAIN;
            S_DRAIN: begin
                // Hold off until the served request's valid has dropped
                if ((op == OP_WRITE) ? !write_valid : !read_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op          <= OP_READ;
            address     <= '0;
            data        <= '0;
            read_ready  <= 1'b0;
            write_ready <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            op          <= op_d;
            address     <= address_d;
            data        <= data_d;
            read_ready  <= read_ready_d;
            write_ready <= write_ready_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder over one shared word array with backdoor
// preload. Define MEM_RESPONDER_STALL_EN to add 0..3 LFSR-driven BUSY cycles.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_responder_if.slave       bus,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0]                   mem [DEPTH];
    logic [NUM_CHANNELS-1:0]                commit_c;
    mem_op_t                                ch_op   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]                   ch_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                   ch_data [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                read_ready;
    logic [NUM_CHANNELS-1:0]                write_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data;
    logic [1:0]                             stall;

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= lfsr_next(lfsr);
    end

    assign stall = lfsr[1:0];
`else
    assign stall = 2'b00;
`endif

    generate
        for (genvar i = 0; i < int'(NUM_CHANNELS); i++) begin : g_ch
            mem_responder_channel #(
                .ADDR_BITS    (ADDR_BITS),
                .DATA_BITS    (DATA_BITS),
                .READ_LATENCY (READ_LATENCY),
                .WRITE_ENABLE (WRITE_ENABLE)
            ) u_ch (
                .clk           (clk),
                .reset_n       (reset_n),
                .read_valid    (bus.mem_read_valid[i]),
                .read_address  (bus.mem_read_address[i]),
                .write_valid   (bus.mem_write_valid[i]),
                .write_address (bus.mem_write_address[i]),
                .write_data    (bus.mem_write_data[i]),
                .stall         (stall),
                .commit_c      (commit_c[i]),
                .op            (ch_op[i]),
                .address       (ch_addr[i]),
                .data          (ch_data[i]),
                .read_ready    (read_ready[i]),
                .write_ready   (write_ready[i])
            );
        end
    endgenerate

    assign bus.mem_read_ready  = read_ready;
    assign bus.mem_write_ready = write_ready;
    assign bus.mem_read_data   = read_data;

    // Array writes: scanning high-to-low lets the lowest channel win, then preload overrides all
    always_ff @(posedge clk) begin
        for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
            if (reset_n && commit_c[i] && (ch_op[i] == OP_WRITE)) begin
                mem[ch_addr[i]] <= ch_data[i];
            end
        end
        if (load_en) begin
            mem[load_address] <= load_data;
        end
    end

    // Read data is sampled pre-write, so a same-edge write is not seen
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_data <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                if (commit_c[i] && (ch_op[i] == OP_READ)) begin
                    read_data[i] <= mem[ch_addr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: a 2-channel writable instance
// plus a 1-channel read-only instance; handles MEM_RESPONDER_STALL_EN builds.
module tb_mem_responder;

    typedef struct {
        int          ch;
        logic [15:0] data;
        int          accept;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_en, ro_load_en;
    logic [7:0] load_address, ro_load_address;
    logic [15:0] load_data, ro_load_data;

    mem_responder_if #(.NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16)) bus ();
    mem_responder_if #(.NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(16)) ro_bus ();

    mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2), .READ_LATENCY(2), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .load_en(load_en), .load_address(load_address), .load_data(load_data)
    );

    mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .READ_LATENCY(2), .WRITE_ENABLE(0)
    ) dut_ro (
        .clk(clk), .reset_n(reset_n), .bus(ro_bus),
        .load_en(ro_load_en), .load_address(ro_load_address), .load_data(ro_load_data)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t rd_q[$];
    exp_t wr_q[$];
    logic [15:0] shadow [64];

    always @(posedge clk) cyc <= cyc + 1;

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (!reset_n) lfsr_m <= 16'hACE1;
        else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
    function automatic int exp_lat();
        return 2 + int'(lfsr_m[1:0]);
    endfunction
`else
    function automatic int exp_lat();
        return 2;
    endfunction
`endif

    // Observation lanes: 0,1 = writable instance channels, 2 = read-only instance
    logic [2:0]  rr, wr;
    logic [15:0] rd [3];
    assign rr    = {ro_bus.mem_read_ready[0], bus.mem_read_ready};
    assign wr    = {ro_bus.mem_write_ready[0], bus.mem_write_ready};
    assign rd[0] = bus.mem_read_data[0];
    assign rd[1] = bus.mem_read_data[1];
    assign rd[2] = ro_bus.mem_read_data[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop the oldest expectation for a lane whenever it reports ready
    always @(negedge clk) begin
        int idx;
        for (int c = 0; c < 3; c++) begin
            if (rr[2'(c)] === 1'b1) begin
                idx = -1;
                for (int k = 0; k < rd_q.size(); k++) if (rd_q[k].ch == c) begin idx = k; break; end
                if (idx < 0) chk($sformatf("unexpected_read_ready_lane%0d", c), 32'd1, 32'd0);
                else begin
                    chk($sformatf("read_data_lane%0d", c), 32'(rd[2'(c)]), 32'(rd_q[idx].data));
                    if (rd_q[idx].lat >= 0)
                        chk($sformatf("read_latency_lane%0d", c), 32'(cyc - rd_q[idx].accept), 32'(rd_q[idx].lat));
                    rd_q.delete(idx);
                end
            end
            if (wr[2'(c)] === 1'b1) begin
                idx = -1;
                for (int k = 0; k < wr_q.size(); k++) if (wr_q[k].ch == c) begin idx = k; break; end
                if (idx < 0) chk($sformatf("unexpected_write_ready_lane%0d", c), 32'd1, 32'd0);
                else begin
                    chk($sformatf("write_latency_lane%0d", c), 32'(cyc - wr_q[idx].accept), 32'(wr_q[idx].lat));
                    wr_q.delete(idx);
                end
            end
        end
    end

    task automatic load(input bit ro, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        if (ro) begin ro_load_en = 1'b1; ro_load_address = a; ro_load_data = d; end
        else    begin load_en    = 1'b1; load_address    = a; load_data    = d; end
        @(negedge clk);
        load_en = 1'b0; ro_load_en = 1'b0;
    endtask

    task automatic rd_req(input int c, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        e.ch = c; e.data = d; e.accept = cyc + 1; e.lat = exp_lat();
        if (c == 2) begin
            ro_bus.mem_read_valid[0] = 1'b1; ro_bus.mem_read_address[0] = a;
        end else begin
            bus.mem_read_valid[1'(c)] = 1'b1; bus.mem_read_address[1'(c)] = a;
        end
        rd_q.push_back(e);
    endtask

    task automatic wr_req(input int c, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        e.ch = c; e.data = d; e.accept = cyc + 1; e.lat = exp_lat();
        bus.mem_write_valid[1'(c)] = 1'b1;
        bus.mem_write_address[1'(c)] = a;
        bus.mem_write_data[1'(c)] = d;
        wr_q.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (rd_q.size() == 0 && wr_q.size() == 0) return;
        end
        chk({tag, "_timeout_pending"}, 32'(rd_q.size() + wr_q.size()), 32'd0);
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic release_all();
        bus.mem_read_valid = '0; bus.mem_write_valid = '0;
        ro_bus.mem_read_valid = '0; ro_bus.mem_write_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        exp_t e;
        reset_n = 1'b0;
        load_en = 1'b0; load_address = '0; load_data = '0;
        ro_load_en = 1'b0; ro_load_address = '0; ro_load_data = '0;
        bus.mem_read_valid = '0; bus.mem_read_address = '0;
        bus.mem_write_valid = '0; bus.mem_write_address = '0; bus.mem_write_data = '0;
        ro_bus.mem_read_valid = '0; ro_bus.mem_read_address = '0;
        ro_bus.mem_write_valid = '0; ro_bus.mem_write_address = '0; ro_bus.mem_write_data = '0;
        repeat (2) @(negedge clk);

        // Preload during reset is legal
        load(1'b0, 8'h10, 16'h1234);
        load(1'b0, 8'h40, 16'h5555);
        load(1'b1, 8'h10, 16'hABCD);
        @(negedge clk); #1;
        chk("reset_read_ready", 32'(rr), 32'd0);
        chk("reset_write_ready", 32'(wr), 32'd0);
        chk("reset_read_data_ch0", 32'(rd[0]), 32'd0);
        chk("reset_read_data_ch1", 32'(rd[1]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Preloaded read; holding valid must not produce a second response
        rd_req(0, 8'h10, 16'h1234);
        wait_done("t1_read");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hold_no_second_ready", 32'(rr[0]), 32'd0);
        end
        chk("hold_data_kept", 32'(rd[0]), 32'h1234);
        release_all();
        rd_req(0, 8'h10, 16'h1234);
        wait_done("t4_reread");
        release_all();

        // Write then read back
        wr_req(0, 8'h20, 16'hBEEF);
        wait_done("t2_write");
        chk("data_held_over_write", 32'(rd[0]), 32'h1234);
        release_all();
        rd_req(0, 8'h20, 16'hBEEF);
        wait_done("t2_read");
        release_all();

        // Same-edge writes to one address: channel 0 wins
        wr_req(0, 8'h30, 16'h0001);
        wr_req(1, 8'h30, 16'h0002);
        wait_done("t3_conflict");
        release_all();
        rd_req(0, 8'h30, 16'h0001);
        rd_req(1, 8'h30, 16'h0001);
        wait_done("t3_readback");
        release_all();

        // Same-edge read and write on one address: read returns old data
        wr_req(0, 8'h40, 16'hAAAA);
        rd_req(1, 8'h40, 16'h5555);
        wait_done("rw_same_edge");
        release_all();
        rd_req(1, 8'h40, 16'hAAAA);
        wait_done("rw_after");
        release_all();

        // Write and read together on one channel: write first, read served later
        bus.mem_read_valid[0] = 1'b1; bus.mem_read_address[0] = 8'h50;
        wr_req(0, 8'h50, 16'hCAFE);
        wait_done("wr_priority_write");
        bus.mem_write_valid[0] = 1'b0;
        e.ch = 0; e.data = 16'hCAFE; e.accept = 0; e.lat = -1;
        rd_q.push_back(e);
        wait_done("wr_priority_read");
        release_all();

        // Read-only instance ignores writes
        ro_bus.mem_write_valid[0] = 1'b1;
        ro_bus.mem_write_address[0] = 8'h10;
        ro_bus.mem_write_data[0] = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("ro_no_write_ready", 32'(wr[2]), 32'd0);
        end
        ro_bus.mem_write_valid[0] = 1'b0;
        @(negedge clk);
        rd_req(2, 8'h10, 16'hABCD);
        wait_done("ro_read");
        release_all();

        // Reset while a read is in BUSY drops it
        rd_req(0, 8'h10, 16'h1234);
        @(negedge clk);
        reset_n = 1'b0;
        rd_q.delete();
        @(negedge clk); #1;
        chk("midreset_ready", 32'(rr[0]), 32'd0);
        chk("midreset_data_ch0", 32'(rd[0]), 32'd0);
        chk("midreset_data_ch1", 32'(rd[1]), 32'd0);
        bus.mem_read_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        rd_req(0, 8'h10, 16'h1234);
        wait_done("midreset_array_intact");
        release_all();

        // Back-to-back reads over random preloaded words
        for (int i = 0; i < 64; i++) begin
            shadow[i] = 16'($urandom);
            load(1'b0, 8'(8'h80 + i), shadow[i]);
        end
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rd_req(i % 2, 8'(8'h80 + i), shadow[i]);
            wait_done("b2b_read");
            release_all();
        end

        chk("final_read_queue_empty", 32'(rd_q.size()), 32'd0);
        chk("final_write_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
